// File: rtl/playback_sequencer_if.sv
// Read-port bus between the playback sequencer and the note RAM.
// The RAM returns mem_q one cycle after the mem_rd strobe.
interface playback_sequencer_if #(
    parameter int unsigned ADDR_W = 6
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [31:0]       mem_q;

    modport master (
        output mem_addr,
        output mem_rd,
        input  mem_q
    );

    modport slave (
        input  mem_addr,
        input  mem_rd,
        output mem_q
    );
endinterface

// File: rtl/playback_sequencer.sv
// Steps through the note RAM once per tempo tick and decodes each word into per-string
// fret codes with a timed note gate for the tone generator.
module playback_sequencer #(
    parameter int unsigned ADDR_W      = 6,
    parameter logic [23:0] GATE_CYCLES = 24'd5000000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 loop,
    input  logic                 tick,
    input  logic [ADDR_W-1:0]    last_addr,
    playback_sequencer_if.master mem_bus,
    output logic [17:0]          fret,
    output logic                 note_strobe,
    output logic                 note_gate,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [2:0] {StIdle, StRead, StCapture, StArm, StLast} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         hold_q, hold_d;
    logic [17:0]         fret_q, fret_d;
    logic                strobe_q, strobe_d;
    logic                done_q, done_d;
    logic                pend_q, pend_d;
    logic [23:0]         gate_cnt_q, gate_cnt_d;
    logic [17:0]         decoded;

    // Bit 6k+s marks string s at position k (0 = open, 1..4 = bar); highest k wins.
    function automatic logic [17:0] decode_word(input logic [31:0] w);
        logic [17:0] f;
        f = '0;
        for (int s = 0; s < 6; s++) begin
            for (int k = 0; k < 5; k++) begin
                if (w[6*k+s]) f[3*s +: 3] = 3'(k + 1);
            end
        end
        return f;
    endfunction

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        hold_d     = hold_q;
        fret_d     = fret_q;
        strobe_d   = 1'b0;
        done_d     = 1'b0;
        pend_d     = pend_q;
        gate_cnt_d = (gate_cnt_q != 24'd0) ? gate_cnt_q - 24'd1 : 24'd0;
        decoded    = decode_word(hold_q);

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRead;
                    addr_d  = '0;
                end
            end
            StRead: begin
                if (tick) pend_d = 1'b1;
                state_d = StCapture;
            end
            StCapture: begin
                if (tick) pend_d = 1'b1;
                hold_d  = mem_bus.mem_q;
                state_d = StArm;
            end
            StArm: begin
                if (tick || pend_q) begin
                    pend_d     = 1'b0;
                    fret_d     = decoded;
                    strobe_d   = 1'b1;
                    // A silent word cuts the previous note off immediately.
                    gate_cnt_d = (decoded != 18'd0) ? GATE_CYCLES : 24'd0;
                    if (addr_q != last_addr) begin
                        addr_d  = addr_q + 1'b1;
                        state_d = StRead;
                    end else if (loop) begin
                        addr_d  = '0;
                        state_d = StRead;
                    end else begin
                        state_d = StLast;
                    end
                end
            end
            StLast: begin
                if (tick) begin
                    fret_d     = '0;
                    gate_cnt_d = 24'd0;
                    done_d     = 1'b1;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Abort overrides everything, including a simultaneous start or completion.
        if (stop) begin
            state_d    = StIdle;
            addr_d     = '0;
            fret_d     = '0;
            strobe_d   = 1'b0;
            done_d     = 1'b0;
            pend_d     = 1'b0;
            gate_cnt_d = 24'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            hold_q     <= '0;
            fret_q     <= '0;
            strobe_q   <= 1'b0;
            done_q     <= 1'b0;
            pend_q     <= 1'b0;
            gate_cnt_q <= 24'd0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            hold_q     <= hold_d;
            fret_q     <= fret_d;
            strobe_q   <= strobe_d;
            done_q     <= done_d;
            pend_q     <= pend_d;
            gate_cnt_q <= gate_cnt_d;
        end
    end

    assign mem_bus.mem_addr = addr_q;
    assign mem_bus.mem_rd   = (state_q == StRead);
    assign fret             = fret_q;
    assign note_strobe      = strobe_q;
    assign note_gate        = (gate_cnt_q != 24'd0);
    assign busy             = (state_q != StIdle);
    assign done             = done_q;

endmodule

// File: doc/playback_sequencer.md
Name: playback_sequencer

Overview:
- Playback-side counterpart of the guitar note recorder.
- Steps through the 64x32 note RAM, one word per tempo tick, starting at address 0.
- Decodes each 30-bit string/bar note word into a per-string fret code.
- Drives a gated note output to the audio stage; sits between the RAM read port and the tone generator, stepped by the clock divider's tick.

Parameters:
- ADDR_W, 6, RAM address width (64 words).
- GATE_CYCLES, 24'd5000000, clk cycles note_gate stays high after each non-silent note (100 ms at 50 MHz).

Ports:
- clk  input  1  system clock (50 MHz).
- reset  input  1  asynchronous, active-high reset.
- start  input  1  level/pulse; begins playback from address 0 when idle.
- stop  input  1  aborts playback in any state.
- loop  input  1  when high, address wraps to 0 after last_addr instead of finishing.
- tick  input  1  one-cycle tempo pulse from clock divider.
- last_addr  input  ADDR_W  final address to play (inclusive).
- mem_q  input  32  RAM read data, valid the cycle after mem_rd.
- mem_addr  output  ADDR_W  RAM read address.
- mem_rd  output  1  read strobe, one cycle.
- fret  output  18  6 strings x 3 bits; string s at [3s+2:3s]; 0=silent, 1=open, 2..5=bar 1..4.
- note_strobe  output  1  one-cycle pulse when fret updates.
- note_gate  output  1  high while the current note sounds.
- busy  output  1  high in any non-IDLE state.
- done  output  1  one-cycle pulse on normal completion.

Behaviour:
- Reset, asynchronous: state=IDLE, mem_addr=0, mem_rd=0, fret=0, note_strobe=0, note_gate=0, gate counter=0, busy=0, done=0, hold register=0, tick_pending=0.
- States:
  - IDLE: start & ~stop -> READ, mem_addr=0.
  - READ: mem_rd=1 for this cycle -> CAPTURE.
  - CAPTURE: hold <= mem_q -> ARM.
  - ARM: on tick or tick_pending, apply hold to outputs and pulse note_strobe. Then:
    - mem_addr != last_addr -> mem_addr+1, READ.
    - mem_addr == last_addr and loop -> mem_addr=0, READ.
    - mem_addr == last_addr and ~loop -> LAST.
  - LAST: on next tick, fret=0, note_gate=0, pulse done -> IDLE.
- Tick timing:
  - A tick in READ or CAPTURE sets tick_pending; ARM consumes and clears it.
  - The first note plays on the first tick after start; fret changes exactly one cycle after the consuming tick/ARM cycle.
- Stop:
  - stop in any state -> IDLE next cycle; fret=0, note_gate=0, gate counter=0, tick_pending=0, mem_addr=0; no done pulse.
  - stop and start together: stop wins.
  - start while busy: ignored.
- Decode, per string s in 0..5:
  - bit k = 6k+s of the word, k=0 open, k=1..4 bar k.
  - fret_s = 1 + highest set k; 0 if none set.
  - Bits 31:30 ignored.
- Gate:
  - On note_strobe with decoded fret != 0: counter loads GATE_CYCLES, and note_gate is high while counter != 0.
  - An all-silent word clears counter and gate in the same cycle.
  - A new non-silent note re-triggers the counter (restarts).
- mem_addr wraps modulo 2^ADDR_W arithmetic never used beyond last_addr; last_addr=0 plays one note.

Test Plan:
- Reset mid-play (assert in ARM with fret=3'd2 on string 0) -> all outputs 0 within same cycle, busy=0.
- RAM[0]=32'h00000041, RAM[1]=32'h0, last_addr=1, loop=0, start, ticks every 100 cycles -> tick1: fret=18'o000002 (string0 bar1, bit6 wins over open bit0), note_gate high; tick2: fret=0, gate low; tick3: done pulse, busy=0.
- GATE_CYCLES=10, RAM[0]=32'h20000000 -> fret string5=3'd5, note_gate high exactly 10 cycles after strobe.
- loop=1, last_addr=2, 7 ticks -> mem_addr sequence 0,1,2,0,1,2,0; no done pulse.
- Tick coincident with mem_rd in READ -> note still applied at ARM one cycle after CAPTURE, no tick lost.
- stop and start together in IDLE -> stays IDLE; stop in ARM -> IDLE, no done, mem_addr=0.
